// File: rtl/pc_unit.sv
// Program counter with branch/jump/exception redirects and a one-deep pending
// redirect slot that holds a target captured while the fetch stage is stalled.
module pc_unit #(
  parameter int unsigned            WIDTH     = 12,
  parameter int unsigned            INC       = 1,
  parameter logic [WIDTH-1:0]       RESET_VEC = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]       EXC_VEC   = 12'hF00
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             pend,
  output logic             wrap
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_s;
  logic [WIDTH-1:0] pend_target_r;
  logic [WIDTH-1:0] pend_target_s;
  logic             wrap_r;
  logic             wrap_s;
  logic [WIDTH:0]   sum_s;
  logic             redirect_req_s;
  logic [WIDTH-1:0] redirect_tgt_s;

  // Branch wins over jump whenever both are requested in the same cycle.
  always_comb begin
    sum_s          = {1'b0, pc_r} + {1'b0, INC_W};
    redirect_req_s = br_taken | jmp;
    if (br_taken) begin
      redirect_tgt_s = br_target;
    end else begin
      redirect_tgt_s = jmp_target;
    end
  end

  // State register; clr takes effect only at a clock edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath selection: exc > stall > branch > jump > increment.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_target_s = pend_target_r;
    wrap_s        = 1'b0;
    if (exc) begin
      state_s       = ST_RUN;
      pc_s          = EXC_VEC;
      pend_target_s = {WIDTH{1'b0}};
    end else if (stall) begin
      if (redirect_req_s) begin
        state_s       = ST_PEND;
        pend_target_s = redirect_tgt_s;
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s = ST_RUN;
      if (redirect_req_s) begin
        pc_s = redirect_tgt_s;
      end else begin
        case (state_r)
          ST_PEND: pc_s = pend_target_r;
          ST_RUN: begin
            pc_s   = sum_s[WIDTH-1:0];
            wrap_s = sum_s[WIDTH];
          end
          default: pc_s = pc_r;
        endcase
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_r          <= RESET_VEC;
      pend_target_r <= {WIDTH{1'b0}};
      wrap_r        <= 1'b0;
    end else begin
      pc_r          <= pc_s;
      pend_target_r <= pend_target_s;
      wrap_r        <= wrap_s;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    pc      = pc_r;
    pc_next = sum_s[WIDTH-1:0];
    wrap    = wrap_r;
    case (state_r)
      ST_PEND: pend = 1'b1;
      ST_RUN:  pend = 1'b0;
      default: pend = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against an arithmetic reference model.
module tb_pc_unit;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [W-1:0]  br_target = '0;
  logic          jmp = 1'b0;
  logic [W-1:0]  jmp_target = '0;
  logic          exc = 1'b0;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_next;
  logic          pend;
  logic          wrap;

  int checks = 0;
  int passes = 0;

  // reference model state
  int m_pc   = 0;
  bit m_pend = 1'b0;
  int m_tgt  = 0;
  bit m_wrap = 1'b0;

  pc_unit #(.WIDTH(12), .INC(1), .RESET_VEC(12'h000), .EXC_VEC(12'hF00)) dut (
    .clk(clk), .clr(clr), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .exc(exc), .pc(pc), .pc_next(pc_next),
    .pend(pend), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step(input bit c, input bit s, input bit b, input int bt,
                      input bit j, input int jt, input bit e);
    int sum;
    clr = c; stall = s; br_taken = b; br_target = W'(bt);
    jmp = j; jmp_target = W'(jt); exc = e;
    @(posedge clk);
    m_wrap = 1'b0;
    if (c) begin
      m_pc = 0; m_pend = 1'b0; m_tgt = 0;
    end else if (e) begin
      m_pc = 'hF00; m_pend = 1'b0;
    end else if (s) begin
      if (b) begin m_pend = 1'b1; m_tgt = bt; end
      else if (j) begin m_pend = 1'b1; m_tgt = jt; end
    end else begin
      if (b) m_pc = bt;
      else if (j) m_pc = jt;
      else if (m_pend) m_pc = m_tgt;
      else begin
        sum = m_pc + 1;
        m_wrap = (sum > 4095);
        m_pc = sum % 4096;
      end
      m_pend = 1'b0;
    end
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("pend", 32'(pend), 32'(m_pend));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("pc_next", 32'(pc_next), 32'((m_pc + 1) % 4096));
  endtask

  task automatic free_step();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic jump_to(input int t);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, t, 1'b0);
  endtask

  initial begin
    int bt, jt;
    bit s, b, j, e, c;

    // reset then free-running count
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    check("reset_pc", 32'(pc), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      free_step();
      check("count_pc", 32'(pc), 32'(i));
    end

    // branch beats jump
    jump_to('h010);
    step(1'b0, 1'b0, 1'b1, 'h200, 1'b1, 'h300, 1'b0);
    check("br_over_jmp", 32'(pc), 32'h200);

    // stalled branch becomes pending, released after stall drops
    jump_to('h020);
    step(1'b0, 1'b1, 1'b1, 'h080, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check("stall_hold_pc", 32'(pc), 32'h020);
    check("stall_pend", 32'(pend), 32'h1);
    free_step();
    check("pend_release_pc", 32'(pc), 32'h080);
    check("pend_release_pend", 32'(pend), 32'h0);

    // overflow wrap pulse
    jump_to('hFFF);
    free_step();
    check("wrap_pc", 32'(pc), 32'h000);
    check("wrap_pulse", 32'(wrap), 32'h1);
    free_step();
    check("wrap_once", 32'(wrap), 32'h0);

    // exception under stall discards pending target
    step(1'b0, 1'b1, 1'b1, 'h080, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    check("exc_pc", 32'(pc), 32'hF00);
    check("exc_pend", 32'(pend), 32'h0);
    free_step();
    check("exc_discard", 32'(pc), 32'hF01);

    // clear while pending
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, 'h123, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check("clr_pend_pc", 32'(pc), 32'h000);
    check("clr_pend_pend", 32'(pend), 32'h0);
    free_step();
    check("clr_pend_inc", 32'(pc), 32'h001);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 4);
      s  = ($urandom_range(0, 99) < 35);
      b  = ($urandom_range(0, 99) < 15);
      j  = ($urandom_range(0, 99) < 15);
      bt = ($urandom_range(0, 9) == 0) ? 'hFFE : int'($urandom_range(0, 4095));
      jt = ($urandom_range(0, 9) == 0) ? 'hFFF : int'($urandom_range(0, 4095));
      step(c, s, b, bt, j, jt, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
